dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter, one access outstanding
// Alternating grant under contention, legality filtering, and memory timeout.
module dmem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_byteen,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_byteen,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_req_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t      state, state_next;
  logic        last_grant, cap_id;
  logic        any_valid, grant, accept, legal, expire, mem_done, rsp_id;
  logic [7:0]  tmo_cnt;
  logic [31:0] sel_addr, sel_wdata, rsp_data;
  logic [3:0]  sel_byteen;

  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    sel_addr   = grant ? req1_addr   : req0_addr;
    sel_wdata  = grant ? req1_wdata  : req0_wdata;
    sel_byteen = grant ? req1_byteen : req0_byteen;
    accept     = (state == IDLE) && any_valid;
    expire     = (tmo_cnt + 8'd1) == TIMEOUT;
    mem_done   = (state == WAIT) && mem_rsp_valid;
    rsp_id     = (state == IDLE) ? grant : cap_id;
    rsp_data   = mem_done ? mem_rdata : 32'd0;
  end

  // Half-words must be 2-byte aligned, words 4-byte aligned.
  always_comb begin
    case (sel_byteen)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: legal = 1'b1;
      4'b0011, 4'b1100:                            legal = ~sel_addr[0];
      4'b1111:                                     legal = (sel_addr[1:0] == 2'b00);
      default:                                     legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = legal ? ISSUE : RESP;
      ISSUE: if (expire) state_next = RESP;
             else if (mem_req_ready) state_next = WAIT;
      WAIT:  if (mem_rsp_valid || expire) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = any_valid & ~grant & ~reset;
        req1_ready = any_valid &  grant & ~reset;
      end
      ISSUE: mem_req_valid = 1'b1;
      RESP: begin
        rsp0_valid = ~cap_id;
        rsp1_valid =  cap_id;
      end
      default: ;
    endcase
  end

  // mem_* double as the captured request; illegal requests never reach memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      cap_id     <= 1'b0;
      tmo_cnt    <= 8'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_byteen <= 4'd0;
      rsp0_rdata <= 32'd0;
      rsp0_err   <= 1'b0;
      rsp1_rdata <= 32'd0;
      rsp1_err   <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        cap_id     <= grant;
        tmo_cnt    <= 8'd0;
        if (legal) begin
          mem_addr   <= sel_addr;
          mem_wdata  <= sel_wdata;
          mem_byteen <= sel_byteen;
        end
      end else if (state == ISSUE || state == WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (state_next == RESP && state != RESP) begin
        if (rsp_id) begin
          rsp1_rdata <= rsp_data;
          rsp1_err   <= ~mem_done;
        end else begin
          rsp0_rdata <= rsp_data;
          rsp0_err   <= ~mem_done;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a transaction-level model
module tb_dmem_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_addr = 0, req1_addr = 0, req0_wdata = 0, req1_wdata = 0;
  logic [3:0]  req0_byteen = 0, req1_byteen = 0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_req_ready = 0, mem_rsp_valid = 0;
  logic [31:0] mem_rdata = 0;

  dmem_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_byteen(req0_byteen), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_byteen(req1_byteen), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy flag, age in cycles, and per-requester results.
  bit          m_busy, m_resp_due, m_issued, m_last, m_id;
  int          m_age;
  logic [31:0] m_mem_addr, m_mem_wdata;
  logic [3:0]  m_mem_be;
  logic [31:0] m_rsp_rdata [2];
  bit          m_rsp_err [2];
  logic        e_r0, e_r1, e_mv, e_v0, e_v1;
  bit          pick;
  bit          log_on = 0;
  int          acc_log[$];

  function automatic bit legal_access(input logic [31:0] a, input logic [3:0] be);
    if (be == 4'b0000 || $countones(be) == 1) return 1'b1;
    if (be == 4'b0011 || be == 4'b1100) return (a % 2) == 0;
    if (be == 4'b1111) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_resp_due = 0; m_issued = 0; m_last = 1; m_id = 0; m_age = 0;
    m_mem_addr = 0; m_mem_wdata = 0; m_mem_be = 0;
    m_rsp_rdata[0] = 0; m_rsp_rdata[1] = 0; m_rsp_err[0] = 0; m_rsp_err[1] = 0;
  endfunction

  function automatic void model_finish(input logic [31:0] d, input bit e);
    m_rsp_rdata[m_id] = d;
    m_rsp_err[m_id] = e;
    m_resp_due = 1;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_strobes", {27'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_req_valid}, 32'd0);
      chk("rst_rsp0_rdata", rsp0_rdata, 32'd0);
      chk("rst_rsp1_rdata", rsp1_rdata, 32'd0);
      chk("rst_errs", {30'd0, rsp0_err, rsp1_err}, 32'd0);
      chk("rst_mem_fields", mem_addr | mem_wdata | {28'd0, mem_byteen}, 32'd0);
      model_reset();
    end else begin
      e_r0 = 0; e_r1 = 0; e_mv = 0; e_v0 = 0; e_v1 = 0;
      pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
      if (!m_busy) begin
        if (req0_valid || req1_valid) begin
          e_r0 = !pick;
          e_r1 = pick;
        end
      end else if (m_resp_due) begin
        e_v0 = !m_id;
        e_v1 = m_id;
      end else if (!m_issued) begin
        e_mv = 1;
      end
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("mem_req_valid", mem_req_valid, e_mv);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("mem_addr", mem_addr, m_mem_addr);
      chk("mem_wdata", mem_wdata, m_mem_wdata);
      chk("mem_byteen", mem_byteen, m_mem_be);
      chk("rsp0_rdata", rsp0_rdata, m_rsp_rdata[0]);
      chk("rsp0_err", rsp0_err, m_rsp_err[0]);
      chk("rsp1_rdata", rsp1_rdata, m_rsp_rdata[1]);
      chk("rsp1_err", rsp1_err, m_rsp_err[1]);
      if (log_on) begin
        chk("excl_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (req0_ready && req0_valid) acc_log.push_back(0);
        if (req1_ready && req1_valid) acc_log.push_back(1);
      end
      if (m_busy) begin
        if (m_resp_due) begin
          m_busy = 0;
          m_resp_due = 0;
        end else begin
          m_age++;
          if (!m_issued) begin
            if (m_age == TMO) model_finish(32'd0, 1);
            else if (mem_req_ready) m_issued = 1;
          end else begin
            if (mem_rsp_valid) model_finish(mem_rdata, 0);
            else if (m_age == TMO) model_finish(32'd0, 1);
          end
        end
      end else if (req0_valid || req1_valid) begin
        m_last = pick;
        m_id = pick;
        m_busy = 1;
        m_age = 0;
        m_issued = 0;
        if (legal_access(pick ? req1_addr : req0_addr, pick ? req1_byteen : req0_byteen)) begin
          m_mem_addr  = pick ? req1_addr : req0_addr;
          m_mem_wdata = pick ? req1_wdata : req0_wdata;
          m_mem_be    = pick ? req1_byteen : req0_byteen;
        end else begin
          model_finish(32'd0, 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input bit id, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] rd,
                         output bit err, output logic [31:0] data);
    bit got;
    got = 0;
    err = 1;
    data = 32'd0;
    if (id) begin
      req1_valid = 1; req1_addr = a; req1_wdata = wd; req1_byteen = be;
    end else begin
      req0_valid = 1; req0_addr = a; req0_wdata = wd; req0_byteen = be;
    end
    step();
    req0_valid = 0;
    req1_valid = 0;
    mem_req_ready = 1;
    mem_rsp_valid = 1;
    mem_rdata = rd;
    for (int c = 0; c < 10 && !got; c++) begin
      if ((id ? rsp1_valid : rsp0_valid) === 1'b1) begin
        got = 1;
        err = id ? rsp1_err : rsp0_err;
        data = id ? rsp1_rdata : rsp0_rdata;
      end else begin
        step();
      end
    end
    chk("txn_response_seen", {31'd0, got}, 32'd1);
    mem_req_ready = 0;
    mem_rsp_valid = 0;
    step();
  endtask

  logic [3:0]  tbl_be   [4] = '{4'b0101, 4'b0011, 4'b0001, 4'b1111};
  logic [31:0] tbl_addr [4] = '{32'h0, 32'h1, 32'h3, 32'h4};
  bit          tbl_err  [4] = '{1, 1, 0, 0};
  int          exp_order [4] = '{0, 1, 0, 1};
  bit          t_err;
  logic [31:0] t_data;

  initial begin
    #2;
    chk("init_mem_addr", mem_addr, 32'd0);
    chk("init_rsp0_rdata", rsp0_rdata, 32'd0);
    step();
    step();
    reset = 0;
    step();

    // Single read: accept, ISSUE, WAIT, RESP at minimum latency.
    req0_valid = 1; req0_addr = 32'h0000_1004; req0_byteen = 4'b0000; req0_wdata = 0;
    #1 chk("t1_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    chk("t1_issue", mem_req_valid, 1);
    chk("t1_addr", mem_addr, 32'h0000_1004);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF;
    chk("t1_wait_no_req", mem_req_valid, 0);
    step();
    mem_rsp_valid = 0;
    chk("t1_rsp_valid", rsp0_valid, 1);
    chk("t1_rsp_rdata", rsp0_rdata, 32'hDEADBEEF);
    chk("t1_rsp_err", rsp0_err, 0);
    step();
    chk("t1_rsp_one_cycle", rsp0_valid, 0);
    chk("t1_rdata_held", rsp0_rdata, 32'hDEADBEEF);

    // Misaligned word write is rejected without touching memory.
    req1_valid = 1; req1_addr = 32'h0000_2002; req1_byteen = 4'b1111; req1_wdata = 32'h55;
    step();
    req1_valid = 0;
    chk("t2_rsp_valid", rsp1_valid, 1);
    chk("t2_rsp_err", rsp1_err, 1);
    chk("t2_rsp_rdata", rsp1_rdata, 32'd0);
    chk("t2_no_mem_req", mem_req_valid, 0);
    step();
    chk("t2_rsp_one_cycle", rsp1_valid, 0);

    // Memory never accepts: request held for TIMEOUT cycles then error.
    req0_valid = 1; req0_addr = 32'h0000_3000; req0_byteen = 4'b1111; req0_wdata = 32'h1122_3344;
    step();
    req0_valid = 0;
    for (int i = 0; i < TMO; i++) begin
      chk("t3_stall_valid", mem_req_valid, 1);
      chk("t3_stall_addr", mem_addr, 32'h0000_3000);
      chk("t3_stall_wdata", mem_wdata, 32'h1122_3344);
      step();
    end
    chk("t3_tmo_valid", rsp0_valid, 1);
    chk("t3_tmo_err", rsp0_err, 1);
    chk("t3_tmo_rdata", rsp0_rdata, 32'd0);
    step();
    chk("t3_back_idle", {31'd0, rsp0_valid | mem_req_valid}, 32'd0);

    // Response lands on the same cycle the timeout would fire.
    req0_valid = 1; req0_addr = 32'h0000_0040; req0_byteen = 4'b0000;
    step();
    req0_valid = 0; mem_req_ready = 0;
    step();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    step();
    mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rsp_valid = 0;
    chk("t4_edge_valid", rsp0_valid, 1);
    chk("t4_edge_err", rsp0_err, 0);
    chk("t4_edge_rdata", rsp0_rdata, 32'hCAFE_F00D);
    step();

    // Reset in WAIT abandons the access; a late memory response is ignored.
    req1_valid = 1; req1_addr = 32'h0000_0080; req1_byteen = 4'b0000;
    step();
    req1_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    reset = 1;
    #1;
    chk("t5_rst_mem_valid", mem_req_valid, 0);
    chk("t5_rst_mem_addr", mem_addr, 32'd0);
    chk("t5_rst_rsp0_rdata", rsp0_rdata, 32'd0);
    chk("t5_rst_rsp1_err", rsp1_err, 0);
    chk("t5_rst_rsp1_valid", rsp1_valid, 0);
    step();
    reset = 0; mem_rsp_valid = 1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_rsp_valid = 0;
    chk("t5_late_rsp_ignored", rsp1_valid, 0);
    run_txn(1, 32'h0000_0106, 32'hAABB_0000, 4'b1100, 32'h77, t_err, t_data);
    chk("t5_next_err", t_err, 0);
    chk("t5_next_rdata", t_data, 32'h77);

    // Legality table.
    for (int i = 0; i < 4; i++) begin
      run_txn(0, tbl_addr[i], 32'h0, tbl_be[i], 32'h100 + i, t_err, t_data);
      chk("t6_err", t_err, tbl_err[i]);
      chk("t6_rdata", t_data, tbl_err[i] ? 32'd0 : 32'h100 + i);
    end

    // Contention from reset: grants alternate starting with requester 0.
    reset = 1;
    req0_valid = 1; req0_addr = 32'h10; req0_byteen = 0;
    req1_valid = 1; req1_addr = 32'h20; req1_byteen = 0;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h5A5A;
    #1;
    chk("t7_no_ready_in_reset", {30'd0, req0_ready, req1_ready}, 32'd0);
    step();
    reset = 0;
    log_on = 1;
    repeat (18) step();
    log_on = 0;
    req0_valid = 0; req1_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    chk("t7_accept_count", {31'd0, acc_log.size() >= 4}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (acc_log.size() > k) chk("t7_order", acc_log[k], exp_order[k]);
    end
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
